divider_scheduler: RTL and testbench
====================================

# divider_scheduler

Shares one iterative `divider` instance among `NUM_REQ` requesters, such as the x/y accumulators of the centroid path, instead of instantiating one divider per channel. Each requester owns one operand slot. A round-robin FSM issues pending slots to the divider one at a time, then returns quotient and remainder to the owning requester with a one-cycle valid pulse.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2–8.
- `WIDTH`, 32: dividend, divisor, quotient and remainder width.

Ports (one clock; reset is synchronous and active-low):
- `clk_in`  in  1  system clock
- `rst_n_in`  in  1  synchronous active-low reset
- `req_valid_in`  in  NUM_REQ  per-requester request strobe
- `req_dividend_in`  in  NUM_REQ*WIDTH  flattened dividends; requester i at [i*WIDTH +: WIDTH]
- `req_divisor_in`  in  NUM_REQ*WIDTH  flattened divisors
- `req_ready_out`  out  NUM_REQ  slot i empty, can accept
- `req_drop_out`  out  NUM_REQ  pulse: strobe arrived while slot full, dropped
- `res_quotient_out`  out  NUM_REQ*WIDTH  last quotient per requester, held
- `res_remainder_out`  out  NUM_REQ*WIDTH  last remainder per requester, held
- `res_valid_out`  out  NUM_REQ  one-cycle pulse: result i updated
- `res_dbz_out`  out  NUM_REQ  pulse with `res_valid_out`: divide-by-zero result
- `busy_out`  out  1  FSM not IDLE

## Operation
**Slot capture**
- `req_valid_in[i] && req_ready_out[i]`: latch the operands, set `pending[i]`, drop ready.
- `req_valid_in[i] && !req_ready_out[i]`: strobe ignored, `req_drop_out[i]` pulses the next cycle, slot contents unchanged.

**FSM** (states IDLE, ISSUE, WAIT)
- IDLE:
  - If any slot is pending, choose a grant by round-robin. Search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - Register the grant and go to ISSUE.
- ISSUE:
  - Drive divider `data_valid_in`=1 for exactly one cycle with the granted operands.
  - Update `last_grant`, go to WAIT.
- WAIT:
  - On divider `data_valid_out`, register quotient and remainder into the granted result registers.
  - Next cycle: pulse `res_valid_out[g]`, clear `pending[g]`, raise `req_ready_out[g]`, return to IDLE.
- The divider is only issued from IDLE→ISSUE, so it is never issued while busy. The divider's `busy_out` is unused.

**Other rules**
- The divider instance gets `rst_in = !rst_n_in`. The divider's width equals `WIDTH`.
- A result register changes only on its own requester's completion.

**Reset** (`rst_n_in`=0, any state, including mid-WAIT)
- FSM goes to IDLE, all `pending` cleared, `last_grant = NUM_REQ-1` (requester 0 wins first).
- All outputs are 0 except `req_ready_out`, which is all-ones.
- An in-flight divider result is discarded, since the divider is reset too.

## Timing
- Accept in cycle 0 → pending visible cycle 1 (IDLE picks) → ISSUE in cycle 2 → divider latency D → `res_valid_out` in cycle 3+D.
- A freed slot shows ready in the same cycle as `res_valid_out`. A strobe in that cycle is accepted.
- Back-to-back grants: after `res_valid_out`, the FSM is in IDLE that cycle. The next ISSUE follows one cycle later.
- Simultaneous capture on several requesters in one cycle is legal. All slots latch.
- Capture of a slot while the FSM serves another slot is legal.

## Configuration
`DIV_SCHED_DBZ_BYPASS_EN`
- Defined:
  - In IDLE, if the granted divisor is 0, skip ISSUE/WAIT.
  - Next cycle: quotient = all-ones, remainder = dividend, `res_valid_out[g]` and `res_dbz_out[g]` pulse, slot freed, FSM in IDLE.
  - `last_grant` is still updated.
- Undefined:
  - Zero divisors go to the divider like any other operand; the result is whatever the divider produces.
  - `res_dbz_out` is tied to 0.

## Structure
- Package `div_sched_pkg`:
  - state enum typedef `sched_state_t` (IDLE, ISSUE, WAIT);
  - `MAX_REQ = 8`;
  - the all-ones quotient constant helper for bypass.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: pending vector, `last_grant`.
  - Outputs: grant index, any-valid.
- The existing `divider` is instantiated once inside.

## Test plan
- Requester 0 sends 100/7 → `res_valid_out[0]` one cycle, quotient 14, remainder 2, `req_ready_out[0]` back to 1, requester 1 outputs untouched.
- Requesters 0 and 1 strobe in the same cycle: 1000/10 and 81/9 → requester 0 completes first (q=100), then requester 1 (q=9). Both re-strobe on completion for 3 rounds → grants strictly alternate 0,1,0,1,0,1.
- Slot 0 pending and strobed again with 5/1 → `req_drop_out[0]` pulses, later result equals the original operands.
- 55/0 with the macro → `res_valid_out` 2 cycles after accept, quotient 0xFFFFFFFF, remainder 55, `res_dbz_out` pulse, divider `data_valid_in` never asserted. Without the macro → divider issued, `res_dbz_out` stays 0.
- Reset asserted during WAIT → no `res_valid_out`, `req_ready_out` all-ones, `busy_out` 0. Then 81/9 on requester 1 → quotient 9, remainder 0.
- Divider shared across requests: exactly one ISSUE per completed request, and `data_valid_in` is never asserted while the FSM is in WAIT.

Source files
------------

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types and constants for the divider scheduler
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  localparam int MAX_REQ   = 8;
  localparam int MAX_WIDTH = 64;

  // Divide-by-zero quotient; callers size-cast it down to their datapath width.
  function automatic logic [MAX_WIDTH-1:0] dbz_quotient();
    return '1;
  endfunction

endpackage

// File: rtl/divider.sv
// rtl/divider.sv - iterative restoring divider, one quotient bit per cycle
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             data_valid_out,
  output logic             busy_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo, rem, dvs, diff;
  logic [WIDTH:0]   shifted;
  logic [CW-1:0]    count;
  logic             done, ge;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs});
    diff    = shifted[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (data_valid_in && count == '0) begin
        quo   <= dividend_in;
        dvs   <= divisor_in;
        rem   <= '0;
        count <= CW'(WIDTH);
      end else if (count != '0) begin
        rem   <= ge ? diff : shifted[WIDTH-1:0];
        quo   <= {quo[WIDTH-2:0], ge};
        count <= count - 1'b1;
        done  <= (count == CW'(1));
      end
    end
  end

  assign quotient_out   = quo;
  assign remainder_out  = rem;
  assign data_valid_out = done;
  assign busy_out       = (count != '0);

endmodule

// File: rtl/divider_scheduler_rr_arbiter.sv
// rtl/divider_scheduler_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               any_valid
);

  logic [GW-1:0] cand;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!any_valid && pending[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

endmodule

// File: rtl/divider_scheduler.sv
// rtl/divider_scheduler.sv - round-robin sharing of one divider among NUM_REQ requesters
// Optional DIV_SCHED_DBZ_BYPASS_EN answers zero divisors directly without using the divider.
module divider_scheduler
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       req_drop_out,
  output logic [NUM_REQ*WIDTH-1:0] res_quotient_out,
  output logic [NUM_REQ*WIDTH-1:0] res_remainder_out,
  output logic [NUM_REQ-1:0]       res_valid_out,
  output logic [NUM_REQ-1:0]       res_dbz_out,
  output logic                     busy_out
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("NUM_REQ out of range");
  end

  sched_state_t state, state_next;

  logic [NUM_REQ-1:0]            pending, drop, res_valid, done_mask;
  logic [NUM_REQ-1:0][WIDTH-1:0] slot_dvd, slot_dvs, res_q, res_r;
  logic [GW-1:0]                 grant, last_grant, arb_grant;
  logic                          arb_any;
  logic                          div_rst, div_valid_in, div_valid_out, div_busy;
  logic [WIDTH-1:0]              div_q, div_r;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
  logic                          bypass;
  logic [NUM_REQ-1:0]            res_dbz;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_arb (
    .pending   (pending),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .any_valid (arb_any)
  );

  assign div_rst = ~rst_n_in;

  divider #(.WIDTH(WIDTH)) u_div (
    .clk_in        (clk_in),
    .rst_in        (div_rst),
    .data_valid_in (div_valid_in),
    .dividend_in   (slot_dvd[grant]),
    .divisor_in    (slot_dvs[grant]),
    .quotient_out  (div_q),
    .remainder_out (div_r),
    .data_valid_out(div_valid_out),
    .busy_out      (div_busy)
  );

  always_comb begin
    state_next   = state;
    div_valid_in = 1'b0;
    done_mask    = '0;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
    bypass       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (arb_any) begin
`ifdef DIV_SCHED_DBZ_BYPASS_EN
          if (slot_dvs[arb_grant] == '0) begin
            bypass               = 1'b1;
            done_mask[arb_grant] = 1'b1;
          end else begin
            state_next = ISSUE;
          end
`else
          state_next = ISSUE;
`endif
        end
      end
      ISSUE: begin
        div_valid_in = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (div_valid_out) begin
          done_mask[grant] = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pending    <= '0;
      drop       <= '0;
      res_valid  <= '0;
      res_q      <= '0;
      res_r      <= '0;
      slot_dvd   <= '0;
      slot_dvs   <= '0;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      drop      <= req_valid_in & pending;
      res_valid <= done_mask;
      // A slot freed this cycle was not ready, so capture never races completion.
      pending   <= (pending & ~done_mask) | (req_valid_in & ~pending);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_in[i] && !pending[i]) begin
          slot_dvd[i] <= req_dividend_in[i*WIDTH +: WIDTH];
          slot_dvs[i] <= req_divisor_in[i*WIDTH +: WIDTH];
        end
      end
      if (state == IDLE && arb_any) grant <= arb_grant;
      if (state == ISSUE)           last_grant <= grant;
      if (state == WAIT && div_valid_out) begin
        res_q[grant] <= div_q;
        res_r[grant] <= div_r;
      end
`ifdef DIV_SCHED_DBZ_BYPASS_EN
      if (bypass) begin
        res_q[arb_grant] <= WIDTH'(dbz_quotient());
        res_r[arb_grant] <= slot_dvd[arb_grant];
        last_grant       <= arb_grant;
      end
`endif
    end
  end

`ifdef DIV_SCHED_DBZ_BYPASS_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) res_dbz <= '0;
    else           res_dbz <= bypass ? done_mask : '0;
  end
  assign res_dbz_out = res_dbz;
`else
  assign res_dbz_out = '0;
`endif

  // Issue only happens from IDLE, after the previous division has fully drained.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && state == ISSUE) assert (!div_busy);
  end

  assign req_ready_out     = ~pending;
  assign req_drop_out      = drop;
  assign res_valid_out     = res_valid;
  assign res_quotient_out  = res_q;
  assign res_remainder_out = res_r;
  assign busy_out          = (state != IDLE);

endmodule

// File: tb/tb_divider_scheduler.sv
// tb/tb_divider_scheduler.sv - scoreboard bench for divider_scheduler
module tb_divider_scheduler;
  import div_sched_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 32;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ*WIDTH-1:0] req_dividend_in, req_divisor_in;
  logic [NUM_REQ-1:0]       req_ready_out, req_drop_out, res_valid_out, res_dbz_out;
  logic [NUM_REQ*WIDTH-1:0] res_quotient_out, res_remainder_out;
  logic                     busy_out;

  divider_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .req_valid_in     (req_valid_in),
    .req_dividend_in  (req_dividend_in),
    .req_divisor_in   (req_divisor_in),
    .req_ready_out    (req_ready_out),
    .req_drop_out     (req_drop_out),
    .res_quotient_out (res_quotient_out),
    .res_remainder_out(res_remainder_out),
    .res_valid_out    (res_valid_out),
    .res_dbz_out      (res_dbz_out),
    .busy_out         (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    bit               chk_qr;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               applied = 0, miscompares = 0;
  int               issues = 0, exp_issues = 0, wait_viol = 0;
  logic [WIDTH-1:0] model_q[NUM_REQ], model_r[NUM_REQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                              input logic dbz, input bit chk_qr);
    exp_t e;
    e.idx = idx; e.q = q; e.r = r; e.dbz = dbz; e.chk_qr = chk_qr;
    return e;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    req_valid_in[i]                  = 1'b1;
    req_dividend_in[i*WIDTH +: WIDTH] = dvd;
    req_divisor_in[i*WIDTH +: WIDTH]  = dvs;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy_out) && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    applied++;
    if (n >= 400) begin
      miscompares++;
      $display("FAIL %s: timeout with %0d results outstanding, required 0", name, sb.size());
    end
  endtask

  // Monitor: pops the scoreboard on every result pulse and checks held results of the others.
  initial begin
    forever begin
      @(negedge clk_in);
      if (dut.div_valid_in) issues++;
      if (dut.div_valid_in && dut.state == WAIT) wait_viol++;
      if (!rst_n_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          model_q[i] = '0;
          model_r[i] = '0;
        end
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (res_valid_out[i]) begin
            if (sb.size() == 0) begin
              applied++;
              miscompares++;
              $display("FAIL unexpected_result: requester %0d pulsed valid, required none", i);
            end else begin
              mon_e = sb.pop_front();
              check("res_idx", 64'(i), 64'(mon_e.idx));
              if (mon_e.chk_qr) begin
                check("res_quotient", 64'(res_quotient_out[i*WIDTH +: WIDTH]), 64'(mon_e.q));
                check("res_remainder", 64'(res_remainder_out[i*WIDTH +: WIDTH]), 64'(mon_e.r));
                model_q[i] = mon_e.q;
                model_r[i] = mon_e.r;
              end else begin
                model_q[i] = res_quotient_out[i*WIDTH +: WIDTH];
                model_r[i] = res_remainder_out[i*WIDTH +: WIDTH];
              end
              check("res_dbz", 64'(res_dbz_out[i]), 64'(mon_e.dbz));
              check("ready_with_valid", 64'(req_ready_out[i]), 64'd1);
              for (int j = 0; j < NUM_REQ; j++) begin
                if (j != i) begin
                  check("other_quotient_held", 64'(res_quotient_out[j*WIDTH +: WIDTH]), 64'(model_q[j]));
                  check("other_remainder_held", 64'(res_remainder_out[j*WIDTH +: WIDTH]), 64'(model_r[j]));
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    int restrobes;
    int n;
    rst_n_in        = 1'b0;
    req_valid_in    = '0;
    req_dividend_in = '0;
    req_divisor_in  = '0;
    repeat (3) @(negedge clk_in);
    check("reset_ready", 64'(req_ready_out), 64'(2'b11));
    check("reset_busy", 64'(busy_out), 64'd0);
    check("reset_res_valid", 64'(res_valid_out), 64'd0);
    check("reset_drop", 64'(req_drop_out), 64'd0);
    check("reset_dbz", 64'(res_dbz_out), 64'd0);
    check("reset_quotient", res_quotient_out, 64'd0);
    check("reset_remainder", res_remainder_out, 64'd0);
    rst_n_in = 1'b1;

    // Single request on requester 0
    @(negedge clk_in);
    set_req(0, 32'd100, 32'd7);
    sb.push_back(mk(0, 32'd14, 32'd2, 1'b0, 1'b1));
    exp_issues++;
    @(negedge clk_in);
    req_valid_in = '0;
    check("ready0_while_pending", 64'(req_ready_out[0]), 64'd0);
    drain("div_100_7");
    check("ready_after_100_7", 64'(req_ready_out), 64'(2'b11));

    // Fresh reset so requester 0 wins first, then strict alternation with re-strobes
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    set_req(0, 32'd1000, 32'd10);
    set_req(1, 32'd81, 32'd9);
    sb.push_back(mk(0, 32'd100, 32'd0, 1'b0, 1'b1));
    sb.push_back(mk(1, 32'd9, 32'd0, 1'b0, 1'b1));
    exp_issues += 2;
    done_cnt  = 0;
    restrobes = 4;
    n         = 0;
    while (done_cnt < 6 && n < 2000) begin
      @(negedge clk_in);
      n++;
      req_valid_in = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (res_valid_out[i]) begin
          check("alternating_grant", 64'(i), 64'(done_cnt % 2));
          done_cnt++;
          if (restrobes > 0) begin
            restrobes--;
            exp_issues++;
            if (i == 0) begin
              set_req(0, 32'd1000, 32'd10);
              sb.push_back(mk(0, 32'd100, 32'd0, 1'b0, 1'b1));
            end else begin
              set_req(1, 32'd81, 32'd9);
              sb.push_back(mk(1, 32'd9, 32'd0, 1'b0, 1'b1));
            end
          end
        end
      end
    end
    req_valid_in = '0;
    check("alternation_rounds", 64'(done_cnt), 64'd6);
    drain("alternation");

    // Strobe into a full slot is dropped and the original operands survive
    @(negedge clk_in);
    set_req(0, 32'd200, 32'd3);
    sb.push_back(mk(0, 32'd66, 32'd2, 1'b0, 1'b1));
    exp_issues++;
    @(negedge clk_in);
    req_valid_in = '0;
    check("drop0_on_accept", 64'(req_drop_out[0]), 64'd0);
    set_req(0, 32'd5, 32'd1);
    @(negedge clk_in);
    req_valid_in = '0;
    check("drop0_pulse", 64'(req_drop_out[0]), 64'd1);
    check("ready0_still_low", 64'(req_ready_out[0]), 64'd0);
    @(negedge clk_in);
    check("drop0_one_cycle", 64'(req_drop_out[0]), 64'd0);
    drain("drop_200_3");

    // Zero divisor on requester 1
    @(negedge clk_in);
    set_req(1, 32'd55, 32'd0);
`ifdef DIV_SCHED_DBZ_BYPASS_EN
    sb.push_back(mk(1, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b1));
`else
    sb.push_back(mk(1, 32'd0, 32'd0, 1'b0, 1'b0));
    exp_issues++;
`endif
    @(negedge clk_in);
    req_valid_in = '0;
    check("dbz_no_early_valid", 64'(res_valid_out), 64'd0);
    @(negedge clk_in);
`ifdef DIV_SCHED_DBZ_BYPASS_EN
    check("dbz_valid_two_cycles", 64'(res_valid_out), 64'(2'b10));
    check("dbz_flag_pulse", 64'(res_dbz_out), 64'(2'b10));
`else
    check("dbz_sent_to_divider", 64'(busy_out), 64'd1);
`endif
    drain("div_55_0");

    // Reset while the divider is mid-computation
    @(negedge clk_in);
    set_req(0, 32'd1000, 32'd7);
    exp_issues++;
    @(negedge clk_in);
    req_valid_in = '0;
    repeat (10) @(negedge clk_in);
    check("busy_before_reset", 64'(busy_out), 64'd1);
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("midwait_reset_ready", 64'(req_ready_out), 64'(2'b11));
    check("midwait_reset_busy", 64'(busy_out), 64'd0);
    check("midwait_reset_valid", 64'(res_valid_out), 64'd0);
    check("midwait_reset_quotient", res_quotient_out, 64'd0);
    rst_n_in = 1'b1;
    repeat (60) @(negedge clk_in);
    set_req(1, 32'd81, 32'd9);
    sb.push_back(mk(1, 32'd9, 32'd0, 1'b0, 1'b1));
    exp_issues++;
    @(negedge clk_in);
    req_valid_in = '0;
    drain("after_reset_81_9");

    check("issue_count", 64'(issues), 64'(exp_issues));
    check("issue_during_wait", 64'(wait_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
